// File: rtl/pulse_channel.sv
// pulse_channel: one tone generator voice. A phase accumulator feeds a
// pulse, sawtooth or triangle waveform, scaled by an envelope level, and
// registered to the output.
//
// Ports
//   i_clk, i_rst    : clock and synchronous active-high reset
//   i_tick_stb      : envelope/length tick (one cycle)
//   i_note_stb      : note trigger (one cycle)
//   i_cfg_valid     : load all i_cfg_* fields
//   i_cfg_delta     : phase increment per clock
//   i_cfg_duty      : 00 12.5%, 01 25%, 10 50%, 11 75%
//   i_cfg_mode      : 00 pulse, 01 saw, 10 triangle, 11 mute
//   i_cfg_volume    : envelope start level
//   i_cfg_decay_en  : envelope falls by one per tick
//   i_cfg_length    : note length in ticks, 0 = unlimited
//   o_output        : registered sample
//   o_frame_pulse   : registered phase MSB
//   o_active        : envelope FSM not IDLE
module pulse_channel #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_tick_stb,
  input  logic               i_note_stb,
  input  logic               i_cfg_valid,
  input  logic [PHASE_W-1:0] i_cfg_delta,
  input  logic [1:0]         i_cfg_duty,
  input  logic [1:0]         i_cfg_mode,
  input  logic [OUT_W-1:0]   i_cfg_volume,
  input  logic               i_cfg_decay_en,
  input  logic [7:0]         i_cfg_length,
  output logic [OUT_W-1:0]   o_output,
  output logic               o_frame_pulse,
  output logic               o_active
);

  typedef enum logic [1:0] {IDLE, SUSTAIN, DECAY} state_t;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase;
  logic [OUT_W-1:0]   env, env_nxt;
  logic [7:0]         len_cnt, len_nxt;

  logic [PHASE_W-1:0] cfg_delta;
  logic [1:0]         cfg_duty;
  logic [1:0]         cfg_mode;
  logic [OUT_W-1:0]   cfg_volume;
  logic               cfg_decay_en;
  logic [7:0]         cfg_length;

  // A note coinciding with a config load starts from the incoming fields.
  logic [OUT_W-1:0]   note_vol;
  logic               note_decay;
  logic [7:0]         note_len;

  assign note_vol   = i_cfg_valid ? i_cfg_volume   : cfg_volume;
  assign note_decay = i_cfg_valid ? i_cfg_decay_en : cfg_decay_en;
  assign note_len   = i_cfg_valid ? i_cfg_length   : cfg_length;

  // Envelope / length FSM. len_cnt is latched at note time, so len_cnt==0
  // while active means the note was started unlimited.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    len_nxt   = len_cnt;
    if (i_note_stb) begin
      env_nxt = note_vol;
      len_nxt = note_len;
      if (note_vol == '0) begin
        state_nxt = IDLE;
        env_nxt   = '0;
      end else begin
        state_nxt = note_decay ? DECAY : SUSTAIN;
      end
    end else if (i_tick_stb && state != IDLE) begin
      if (len_cnt != 8'd0)
        len_nxt = len_cnt - 8'd1;
      if (state == DECAY && env != '0)
        env_nxt = env - OUT_W'(1);
      if (len_cnt == 8'd1 || (state == DECAY && env <= OUT_W'(1))) begin
        state_nxt = IDLE;
        env_nxt   = '0;
      end
    end
  end

  // Waveform generation from the current phase and envelope.
  logic                 pulse_hi;
  logic [OUT_W-1:0]     wave;
  logic [2*OUT_W-1:0]   prod;
  logic [OUT_W-1:0]     sample;

  always_comb begin
    pulse_hi = 1'b0;
    case (cfg_duty)
      2'b00: pulse_hi = (phase[PHASE_W-1 -: 3] == 3'b000);
      2'b01: pulse_hi = (phase[PHASE_W-1 -: 2] == 2'b00);
      2'b10: pulse_hi = ~phase[PHASE_W-1];
      2'b11: pulse_hi = (phase[PHASE_W-1 -: 2] != 2'b11);
      default: pulse_hi = 1'b0;
    endcase
  end

  always_comb begin
    wave = '0;
    if (cfg_mode == 2'b01)
      wave = phase[PHASE_W-1 -: OUT_W];
    else if (phase[PHASE_W-1])
      wave = ~phase[PHASE_W-2 -: OUT_W];
    else
      wave = phase[PHASE_W-2 -: OUT_W];
  end

  assign prod = {{OUT_W{1'b0}}, wave} * {{OUT_W{1'b0}}, env};

  always_comb begin
    sample = '0;
    if (state != IDLE) begin
      case (cfg_mode)
        2'b00:         sample = pulse_hi ? env : '0;
        2'b01, 2'b10:  sample = prod[2*OUT_W-1 -: OUT_W];
        default:       sample = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      phase         <= '0;
      env           <= '0;
      len_cnt       <= '0;
      cfg_delta     <= '0;
      cfg_duty      <= '0;
      cfg_mode      <= 2'b11;
      cfg_volume    <= '0;
      cfg_decay_en  <= 1'b0;
      cfg_length    <= '0;
      o_output      <= '0;
      o_frame_pulse <= 1'b0;
    end else begin
      if (i_cfg_valid) begin
        cfg_delta    <= i_cfg_delta;
        cfg_duty     <= i_cfg_duty;
        cfg_mode     <= i_cfg_mode;
        cfg_volume   <= i_cfg_volume;
        cfg_decay_en <= i_cfg_decay_en;
        cfg_length   <= i_cfg_length;
      end
      phase         <= i_note_stb ? '0 : phase + cfg_delta;
      state         <= state_nxt;
      env           <= env_nxt;
      len_cnt       <= len_nxt;
      o_output      <= sample;
      o_frame_pulse <= phase[PHASE_W-1];
    end
  end

  assign o_active = (state != IDLE);

endmodule

// File: tb/tb_pulse_channel.sv
module tb_pulse_channel;

  logic        clk = 1'b0;
  logic        rst, tick, note, cfg_valid;
  logic [31:0] delta;
  logic [1:0]  duty, mode;
  logic [8:0]  volume;
  logic        decay_en;
  logic [7:0]  length;
  logic [8:0]  out;
  logic        frame, active;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  pulse_channel #(.PHASE_W(32), .OUT_W(9)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick_stb(tick), .i_note_stb(note),
    .i_cfg_valid(cfg_valid), .i_cfg_delta(delta), .i_cfg_duty(duty),
    .i_cfg_mode(mode), .i_cfg_volume(volume), .i_cfg_decay_en(decay_en),
    .i_cfg_length(length), .o_output(out), .o_frame_pulse(frame),
    .o_active(active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then drop one-cycle strobes.
  task automatic cycle();
    @(negedge clk);
    tick = 1'b0; note = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] d, input logic [1:0] du, input logic [1:0] m,
                         input logic [8:0] v, input logic de, input logic [7:0] l);
    cfg_valid = 1'b1; delta = d; duty = du; mode = m;
    volume = v; decay_en = de; length = l;
  endtask

  int saw_exp [5] = '{0, 25, 50, 75, 0};
  int tri_exp [5] = '{0, 50, 99, 49, 0};

  initial begin
    rst = 1'b1; tick = 1'b0; note = 1'b0; cfg_valid = 1'b0;
    delta = '0; duty = '0; mode = '0; volume = '0; decay_en = 1'b0; length = '0;
    @(negedge clk);
    cycle(); cycle();
    check("reset_out", out, 0);
    check("reset_frame", frame, 0);
    check("reset_active", active, 0);
    rst = 1'b0;
    cycle();

    // 50% pulse, period 4
    set_cfg(32'h4000_0000, 2'b10, 2'b00, 9'd100, 1'b0, 8'd0); note = 1'b1;
    cycle();
    check("p50_active", active, 1);
    for (int j = 0; j < 8; j++) begin
      cycle();
      check("p50_out", out, (j % 4 < 2) ? 100 : 0);
      check("p50_frame", frame, (j % 4 >= 2) ? 1 : 0);
    end

    // 12.5% pulse, 1 of 8
    set_cfg(32'h2000_0000, 2'b00, 2'b00, 9'd100, 1'b0, 8'd0); note = 1'b1;
    cycle();
    for (int j = 0; j < 16; j++) begin
      cycle();
      check("p125_out", out, (j % 8 == 0) ? 100 : 0);
    end

    // sawtooth and triangle scaling
    set_cfg(32'h4000_0000, 2'b00, 2'b01, 9'd100, 1'b0, 8'd0); note = 1'b1;
    cycle();
    for (int j = 0; j < 5; j++) begin
      cycle();
      check("saw_out", out, saw_exp[j]);
    end
    set_cfg(32'h4000_0000, 2'b00, 2'b10, 9'd100, 1'b0, 8'd0); note = 1'b1;
    cycle();
    for (int j = 0; j < 5; j++) begin
      cycle();
      check("tri_out", out, tri_exp[j]);
    end

    // decay 3,2,1,0 (75% duty, delta 0 keeps pulse high)
    set_cfg(32'h0, 2'b11, 2'b00, 9'd3, 1'b1, 8'd0); note = 1'b1;
    cycle(); cycle();
    check("dec_env3", out, 3);
    tick = 1'b1; cycle(); cycle();
    check("dec_env2", out, 2);
    check("dec_active2", active, 1);
    tick = 1'b1; cycle(); cycle();
    check("dec_env1", out, 1);
    tick = 1'b1; cycle();
    check("dec_active0", active, 0);
    for (int j = 0; j < 3; j++) begin
      cycle();
      check("dec_out0", out, 0);
    end

    // length 2
    set_cfg(32'h0, 2'b11, 2'b00, 9'd50, 1'b0, 8'd2); note = 1'b1;
    cycle(); cycle();
    check("len_out", out, 50);
    tick = 1'b1; cycle();
    check("len_active1", active, 1);
    tick = 1'b1; cycle();
    check("len_active0", active, 0);
    cycle();
    check("len_out0", out, 0);

    // length 0: unlimited
    set_cfg(32'h0, 2'b11, 2'b00, 9'd50, 1'b0, 8'd0); note = 1'b1;
    cycle();
    for (int j = 0; j < 300; j++) begin
      tick = 1'b1; cycle();
    end
    check("unl_active", active, 1);
    cycle();
    check("unl_out", out, 50);

    // volume deferred to next note, mode immediate
    set_cfg(32'h0, 2'b11, 2'b00, 9'd7, 1'b0, 8'd0);
    cycle(); cycle();
    check("defer_vol", out, 50);
    set_cfg(32'h0, 2'b11, 2'b11, 9'd7, 1'b0, 8'd0);
    cycle(); cycle();
    check("mute_out", out, 0);
    check("mute_active", active, 1);
    set_cfg(32'h0, 2'b11, 2'b00, 9'd7, 1'b0, 8'd0);
    cycle();
    note = 1'b1;
    cycle(); cycle();
    check("newvol_out", out, 7);

    // note wins over coincident tick
    set_cfg(32'h0, 2'b11, 2'b00, 9'd5, 1'b1, 8'd0); note = 1'b1; tick = 1'b1;
    cycle(); cycle();
    check("coinc_out", out, 5);
    check("coinc_active", active, 1);

    // reset mid-note, then note with reset (mute, zero volume) config
    set_cfg(32'h8000_0000, 2'b11, 2'b00, 9'd100, 1'b0, 8'd0); note = 1'b1;
    cycle(); cycle(); cycle();
    check("pre_rst_out", out, 100);
    check("pre_rst_frame", frame, 1);
    rst = 1'b1; note = 1'b1; tick = 1'b1;
    set_cfg(32'h8000_0000, 2'b11, 2'b00, 9'd100, 1'b0, 8'd0);
    cycle();
    check("rst_out", out, 0);
    check("rst_frame", frame, 0);
    check("rst_active", active, 0);
    rst = 1'b0; note = 1'b1;
    cycle();
    check("post_rst_active", active, 0);
    for (int j = 0; j < 4; j++) begin
      cycle();
      check("post_rst_out", out, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
